// File: rtl/aes_inv_key_schedule_if.sv
// Handshake bundle between the inverse key schedule and the decipher round engine.
// AES_INV_KS_CHECK_EN adds the reference-key check signals.
interface aes_inv_key_schedule_if;
  logic         start;
  logic [127:0] lastKey;
  logic [127:0] roundKey;
  logic [3:0]   roundIdx;
  logic         keyValid;
  logic         keyReady;
  logic         busy;
  logic         done;
`ifdef AES_INV_KS_CHECK_EN
  logic [127:0] cipherKeyRef;
  logic         keyMismatch;
`endif

  modport master (
    output start, lastKey, keyReady,
    input  roundKey, roundIdx, keyValid, busy, done
`ifdef AES_INV_KS_CHECK_EN
    , output cipherKeyRef
    , input  keyMismatch
`endif
  );

  modport slave (
    input  start, lastKey, keyReady,
    output roundKey, roundIdx, keyValid, busy, done
`ifdef AES_INV_KS_CHECK_EN
    , input  cipherKeyRef
    , output keyMismatch
`endif
  );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: loads round key 10 and steps backwards to round key 0,
// one key per accepted handshake. Optional reference check under AES_INV_KS_CHECK_EN.
module aes_inv_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  aes_inv_key_schedule_if.slave    ks
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Left byte rotate followed by four sbox lookups.
  function automatic logic [31:0] rot_word_sub_bytes(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  state_t       state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic         key_valid_q, key_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
`ifdef AES_INV_KS_CHECK_EN
  logic         key_mismatch_q, key_mismatch_d;
`endif

  logic [7:0]   rcon;
  logic [31:0]  w0_prev, w1_prev, w2_prev, w3_prev;
  logic [127:0] prev_key;

  always_comb begin
    case (round_idx_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Undo one forward expansion step; w3' must be formed before it feeds the word transform.
  always_comb begin
    w3_prev  = round_key_q[31:0]   ^ round_key_q[63:32];
    w2_prev  = round_key_q[63:32]  ^ round_key_q[95:64];
    w1_prev  = round_key_q[95:64]  ^ round_key_q[127:96];
    w0_prev  = round_key_q[127:96] ^ rot_word_sub_bytes(w3_prev) ^ {rcon, 24'h0};
    prev_key = {w0_prev, w1_prev, w2_prev, w3_prev};
  end

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    key_valid_d = key_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef AES_INV_KS_CHECK_EN
    key_mismatch_d = key_mismatch_q;
`endif
    case (state_q)
      IDLE: begin
        key_valid_d = 1'b0;
        if (ks.start) begin
          round_key_d = ks.lastKey;
          round_idx_d = 4'(NUM_ROUNDS);
          key_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = RUN;
`ifdef AES_INV_KS_CHECK_EN
          key_mismatch_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (key_valid_q && ks.keyReady) begin
          if (round_idx_q != 4'd0) begin
            round_key_d = prev_key;
            round_idx_d = round_idx_q - 4'd1;
          end else begin
            key_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
`ifdef AES_INV_KS_CHECK_EN
            key_mismatch_d = (round_key_q != ks.cipherKeyRef);
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_idx_q <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef AES_INV_KS_CHECK_EN
      key_mismatch_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef AES_INV_KS_CHECK_EN
      key_mismatch_q <= key_mismatch_d;
`endif
    end
  end

  assign ks.roundKey = round_key_q;
  assign ks.roundIdx = round_idx_q;
  assign ks.keyValid = key_valid_q;
  assign ks.busy     = busy_q;
  assign ks.done     = done_q;
`ifdef AES_INV_KS_CHECK_EN
  assign ks.keyMismatch = key_mismatch_q;
`endif

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: a forward AES-128 key expansion model predicts the
// reversed key stream, checked every cycle, plus literal FIPS-197 values.
module tb_aes_inv_key_schedule;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9_A  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K10_Z = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_inv_key_schedule_if ks();
  aes_inv_key_schedule dut (.clk(clk), .reset(reset), .ks(ks));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // All 11 round keys from the cipher key; round r sits at [r*128 +: 128].
  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [1407:0] flat;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      flat[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return flat;
  endfunction

  // ---------------- cycle-by-cycle compare ----------------
  logic [127:0]  cur_cipher = '0;
  logic [1407:0] exp_flat;
  bit  active = 0, done_exp = 0, after_reset = 0, key_chk = 1;
  int  exp_idx = 0, xfers = 0, last_xfers = 0;
  bit  mm_exp = 0, mm_run_exp = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_keyValid", ks.keyValid, 0);
      chk("rst_busy", ks.busy, 0);
      chk("rst_done", ks.done, 0);
      chk("rst_roundIdx", ks.roundIdx, 0);
      chk("rst_roundKey", ks.roundKey, 0);
`ifdef AES_INV_KS_CHECK_EN
      chk("rst_keyMismatch", ks.keyMismatch, 0);
`endif
      active = 0; done_exp = 0; after_reset = 1; mm_exp = 0;
    end else begin
      chk("done", ks.done, done_exp);
      chk("busy", ks.busy, active);
      chk("keyValid", ks.keyValid, active);
`ifdef AES_INV_KS_CHECK_EN
      chk("keyMismatch", ks.keyMismatch, mm_exp);
`endif
      if (active) begin
        chk("roundIdx", ks.roundIdx, exp_idx);
        if (key_chk) chk("roundKey", ks.roundKey, exp_flat[exp_idx*128 +: 128]);
      end else if (after_reset) begin
        chk("idle_roundKey", ks.roundKey, 0);
        chk("idle_roundIdx", ks.roundIdx, 0);
      end
      // predict the state after the coming rising edge
      done_exp = 0;
      if (active) begin
        if (ks.keyReady) begin
          xfers++;
          if (exp_idx == 0) begin
            active = 0; done_exp = 1; last_xfers = xfers; mm_exp = mm_run_exp;
          end else begin
            exp_idx--;
          end
        end
      end else if (ks.start) begin
        active = 1; exp_idx = 10; xfers = 0; after_reset = 0; mm_exp = 0;
        exp_flat = expand(cur_cipher);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input logic [127:0] cipher, input logic [127:0] lk);
    cur_cipher = cipher;
    ks.lastKey = lk;
    ks.start = 1'b1;
    @(posedge clk); #1;
    ks.start = 1'b0;
  endtask

  task automatic run_until_done(input bit rnd, input bit stall_at4, input int pulse_idx,
                                output logic [127:0] r0_key);
    int cyc = 0;
    int stalls = 0;
    bit pulsed = 0;
    r0_key = '1;
    while (ks.done !== 1'b1 && cyc < 200) begin
      if (ks.keyValid && ks.roundIdx == 4'd0) r0_key = ks.roundKey;
      if (stall_at4 && ks.keyValid && ks.roundIdx == 4'd4 && stalls < 5) begin
        ks.keyReady = 1'b0; stalls++;
      end else begin
        ks.keyReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (!pulsed && pulse_idx >= 0 && ks.keyValid && ks.roundIdx == 4'(pulse_idx)) begin
        ks.start = 1'b1; ks.lastKey = K10_Z; pulsed = 1;
      end else begin
        ks.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ks.start = 1'b0;
    chk("done_reached", ks.done, 1);
    chk("transfers", 128'(last_xfers), 11);
    if (stall_at4) chk("stall_cycles", 128'(stalls), 5);
  endtask

  logic [1407:0] model_a, model_z;
  logic [127:0]  r0;

  initial begin
    ks.start = 1'b0; ks.lastKey = '0; ks.keyReady = 1'b0;
`ifdef AES_INV_KS_CHECK_EN
    ks.cipherKeyRef = KEY_A;
`endif
    build_sbox();
    model_a = expand(KEY_A);
    model_z = expand('0);
    chk("model_a_k10", model_a[1280 +: 128], K10_A);
    chk("model_a_k9", model_a[1152 +: 128], K9_A);
    chk("model_z_k10", model_z[1280 +: 128], K10_Z);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 A.1, consumer always ready: literal latency points
    ks.keyReady = 1'b1;
    do_start(KEY_A, K10_A);
    chk("a1_c1_key", ks.roundKey, K10_A);
    chk("a1_c1_idx", ks.roundIdx, 10);
    @(posedge clk); #1;
    chk("a1_c2_key", ks.roundKey, K9_A);
    repeat (9) @(posedge clk);
    #1;
    chk("a1_c11_key", ks.roundKey, KEY_A);
    chk("a1_c11_idx", ks.roundIdx, 0);
    chk("a1_c11_done", ks.done, 0);
    @(posedge clk); #1;
    chk("a1_c12_done", ks.done, 1);
    chk("a1_c12_valid", ks.keyValid, 0);
    ks.keyReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // random backpressure with a 5-cycle stall at round 4
    do_start(KEY_A, K10_A);
    run_until_done(1, 1, -1, r0);
    chk("bp_round0", r0, KEY_A);

    // start during RUN ignored, then back-to-back start with the all-zero cipher key
    ks.keyReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_start(KEY_A, K10_A);
    run_until_done(0, 0, 7, r0);
    chk("ign_round0", r0, KEY_A);
    do_start('0, K10_Z);
    run_until_done(0, 0, -1, r0);
    chk("b2b_round0", r0, 128'h0);

`ifdef AES_INV_KS_CHECK_EN
    ks.cipherKeyRef = KEY_A;
    mm_run_exp = 0;
    do_start(KEY_A, K10_A);
    run_until_done(0, 0, -1, r0);
    chk("mm_clean", ks.keyMismatch, 0);
    key_chk = 0; mm_run_exp = 1;
    do_start(KEY_A, K10_A ^ 128'h1);
    run_until_done(1, 0, -1, r0);
    chk("mm_flip", ks.keyMismatch, 1);
    key_chk = 1; mm_run_exp = 0;
    do_start(KEY_A, K10_A);
    chk("mm_cleared", ks.keyMismatch, 0);
    run_until_done(0, 0, -1, r0);
`endif

    // reset in the middle of a run at round 6
    ks.keyReady = 1'b1;
    do_start(KEY_A, K10_A);
    for (int i = 0; i < 30 && ks.roundIdx != 4'd6; i++) begin
      @(posedge clk); #1;
    end
    chk("reach_idx6", ks.roundIdx, 6);
    reset = 1'b1;
    #2;
    chk("rstmid_valid", ks.keyValid, 0);
    chk("rstmid_busy", ks.busy, 0);
    chk("rstmid_idx", ks.roundIdx, 0);
    chk("rstmid_key", ks.roundKey, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_valid", ks.keyValid, 0);
    chk("post_rst_busy", ks.busy, 0);
    ks.keyReady = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
Sequential AES-128 inverse key schedule for the decryption datapath. Loads the final (round-10) round key and walks the key expansion backwards, emitting round keys 10, 9, …, 0, one per accepted handshake. The decipher round engine consumes keys in this order without storing all 11 keys. Reuses the team's rotWord_subBytes word transform, one instance with 4 sbox lookups, on a single combinational step per round.

Parameters:
NUM_ROUNDS, 10, number of backward steps; fixed at 10 for AES-128, other values unsupported.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  load request; sampled only in IDLE
lastKey  input  128  round-10 key; word0 = [127:96]
roundKey  output  128  current round key
roundIdx  output  4  round number of roundKey (10 down to 0)
keyValid  output  1  roundKey/roundIdx valid
keyReady  input  1  consumer accepts current key
busy  output  1  high in RUN
done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (async, active-high): state=IDLE, roundKey=0, roundIdx=0, keyValid=0, busy=0, done=0. Reset mid-run abandons the sequence. After reset is released, a new start is required.
- States: IDLE, RUN.
- IDLE with start=1 at the clock edge: register lastKey into roundKey, set roundIdx=10, keyValid=1, busy=1, state=RUN. Latency from start to first valid key is 1 cycle.
- IDLE with start=0: all outputs hold; keyValid=0.
- RUN, transfer = keyValid & keyReady at the edge:
  - roundIdx>0: roundKey ← prev(roundKey, roundIdx), roundIdx ← roundIdx−1, keyValid stays 1. Back-to-back transfers give one key per cycle.
  - roundIdx==0: keyValid←0, busy←0, done←1 for exactly one cycle, state=IDLE.
- RUN with no transfer (keyReady=0): roundKey and roundIdx hold stable; no combinational path from keyReady to the outputs.
- prev(k, r), with k = {w0,w1,w2,w3}:
  - w3' = w3^w2
  - w2' = w2^w1
  - w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r],24'h0}
  - Result is {w0',w1',w2',w3'}.
  - RotWord is a left byte rotate.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36, implemented as a case ROM indexed by roundIdx.
- start while in RUN is ignored and does not restart the sequence.
- done and start may coincide: start is ignored on the same edge done is set, because state is still RUN at that edge. start is accepted from the next cycle.
- Total sequence: 11 transfers; minimum 12 cycles from start to done.

Optional Feature:
- Macro: AES_INV_KS_CHECK_EN.
- When defined:
  - Adds input cipherKeyRef [127:0] and output keyMismatch [1].
  - On the round-0 transfer, keyMismatch is registered as (roundKey != cipherKeyRef) and held until the next accepted start or reset. Reset value is 0.
  - This flags a corrupted or incorrect lastKey.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset/idle: assert reset mid-RUN at roundIdx=6 → next sample shows keyValid=0, busy=0, roundIdx=0, roundKey=0; the module then ignores keyReady until a new start.
- FIPS-197 A.1 with keyReady=1: start with lastKey=d014f9a8c9ee2589e13f0cc8b6630ca6 → cycle+1: idx10 = that key; cycle+2: idx9 = ac7766f319fadc2128d12941575c006e; cycle+11: idx0 = 2b7e151628aed2a6abf7158809cf4f3c; done pulses at cycle+12.
- Backpressure: same vector with keyReady toggling randomly and held low 5 cycles at idx4 → the key sequence is identical, keys stay stable while stalled, and exactly 11 transfers occur.
- Start during RUN: pulse start with a different lastKey at idx7 → ignored; the original sequence completes unchanged.
- Back-to-back: assert start in the cycle after done with lastKey from a second key schedule (all-zero cipher key, round-10 key b4ef5bcb3e92e21123e951cf6f8f188e) → round 0 = 00000000000000000000000000000000.
- AES_INV_KS_CHECK_EN: run the A.1 vector with cipherKeyRef=2b7e…4f3c → keyMismatch=0; repeat with one bit of lastKey flipped → keyMismatch=1 after the round-0 transfer, cleared by the next start.
